alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Multi-cycle execute controller that drives the 16-bit ALU.
- Accepts one decoded TSC instruction per handshake and issues the ALU function code and operand selects.
- Consumes the ALU branch result and sequences memory access, register writeback and PC update.
- Sits between the decode stage and the ALU/register-file/memory datapath.

Parameters:
- MEM_TIMEOUT, 0, maximum number of S_MEM cycles before `illegal` is raised and the access is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- inst_valid  in  1  decode presents an instruction.
- inst_ready  out  1  controller can accept an instruction.
- opcode  in  4  instruction opcode.
- func  in  6  R-type function field.
- alu_func_code  out  5  ALU function select (`ALU_*` codes from opcodes.v).
- alu_src_imm  out  1  ALU op2 = sign-extended immediate (0 = rt register).
- alu_op1_zero  out  1  ALU op1 forced to 0; used for LHI.
- alu_b_result  in  1  ALU branch condition result.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- mem_ack  in  1  memory completes the request.
- reg_write  out  1  register-file write strobe.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+1 link.
- output_en  out  1  WWD output strobe.
- branch_taken  out  1  valid while `done` is high.
- jump  out  1  valid while `done` is high.
- done  out  1  one-cycle instruction-complete pulse; PC update allowed.
- halted  out  1  HLT executed.
- illegal  out  1  one-cycle pulse on an undefined opcode/func or a memory timeout.

Behaviour:
- Reset: reset_n low at a rising edge puts the FSM in S_IDLE and clears the latched instruction, branch_taken and the timeout counter. Reset overrides any state, including S_MEM and S_HALT. In the following cycle inst_ready = 1 and all other outputs are 0.
- All outputs are Moore functions of the state register and the latched opcode/func. There are no combinational paths from inputs to outputs.
- Handshake: a transfer occurs when inst_valid && inst_ready at a rising edge. inst_ready is high only in S_IDLE. opcode and func are latched on the transfer edge.
- Decode map:
  - R-type: opcode 15, func 0..7 → ALU_ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR; alu_src_imm = 0.
  - ADI/LWD/SWD (opcodes 4/7/8) → ALU_ADD, alu_src_imm = 1.
  - ORI (5) → ALU_ORR, alu_src_imm = 1.
  - LHI (6) → ALU_ORR, alu_src_imm = 1, alu_op1_zero = 1.
  - BNE/BEQ/BGZ/BLZ (0..3) → ALU_BNE/BEQ/BGZ/BLZ, alu_src_imm = 0.
  - JMP (9), JAL (10), and opcode 15 with func 25..28 (WWD, JPR, JRL, HLT): no ALU use; alu_func_code = ALU_ADD.
- S_IDLE: on transfer go to S_EXEC.
- S_EXEC (1 cycle): drive the decoded ALU controls. Next state:
  - Branches: register branch_taken = alu_b_result at the exit edge, then go to S_DONE.
  - LWD/SWD: go to S_MEM.
  - ALU ops, JAL, JRL: go to S_WB.
  - WWD: output_en = 1 this cycle, then S_DONE.
  - JMP/JPR: go to S_DONE.
  - HLT: go to S_HALT.
  - Undefined opcode/func: illegal = 1 this cycle, then S_DONE as a NOP.
- S_MEM: hold mem_read (LWD) or mem_write (SWD) and ALU_ADD controls until mem_ack, then LWD → S_WB, SWD → S_DONE. If MEM_TIMEOUT > 0 and that many cycles pass without mem_ack: illegal pulse, then S_DONE with no writeback. mem_ack outside S_MEM is ignored.
- S_WB (1 cycle): reg_write = 1. wb_sel = 1 for LWD, 2 for JAL/JRL, 0 otherwise. Then S_DONE.
- S_DONE (1 cycle): done = 1. jump = 1 for JMP/JAL/JPR/JRL. branch_taken is valid. Then S_IDLE.
- S_HALT: halted = 1, inst_ready = 0; exit only by reset.
- Latency from the transfer edge to done high:
  - Branch, JMP, WWD: 2 cycles.
  - R-type ALU op: 3 cycles.
  - LWD: 4 + (mem wait) cycles.
  - SWD: 3 + (mem wait) cycles.
- Throughput: the next instruction is accepted on the cycle after done (back in S_IDLE).

Optional Feature:
- Macro: ALU_EXEC_CTRL_STATS_EN.
- Defined: adds outputs `instr_count` (16 bit) and `taken_count` (16 bit).
  - instr_count increments on each done pulse.
  - taken_count increments on done && branch_taken.
  - Both wrap from 16'hFFFF to 0 and clear on reset.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Test Plan:
- Reset then R-type ADD (opcode 15, func 0) → alu_func_code = ALU_ADD, alu_src_imm = 0 in EXEC; reg_write with wb_sel = 0 at cycle 2; done at cycle 3.
- BEQ with alu_b_result = 1, then BNE with alu_b_result = 0 → done at cycle 2 each; branch_taken = 1, then 0; reg_write never asserted.
- LWD with mem_ack delayed 3 cycles → mem_read high for 4 cycles, then reg_write with wb_sel = 1; done 7 cycles after transfer. SWD with immediate ack → mem_write for 1 cycle, no reg_write.
- HLT → halted = 1 and inst_ready = 0 indefinitely with inst_valid held high; reset_n low for 1 cycle → S_IDLE, halted = 0.
- Reset asserted during S_MEM (LWD, no ack) → next cycle inst_ready = 1; mem_read, reg_write and done never pulse.
- opcode 15, func 12 → illegal pulse, done at cycle 2, no reg_write. With ALU_EXEC_CTRL_STATS_EN defined, instr_count = 1 after this instruction.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute controller for the 16-bit TSC ALU.
// Accepts one decoded instruction per valid/ready handshake, drives the ALU
// function code and operand selects, then sequences memory access, register
// writeback and the PC-update strobe (done).
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   inst_valid/inst_ready    decode handshake; opcode/func latched on transfer
//   alu_func_code, alu_src_imm, alu_op1_zero   ALU controls
//   alu_b_result             branch condition from the ALU
//   mem_read, mem_write, mem_ack               data memory request/complete
//   reg_write, wb_sel        register writeback strobe and source
//   output_en                WWD strobe
//   branch_taken, jump, done PC update qualifiers (valid with done)
//   halted, illegal          HLT status, undefined-op / memory-timeout pulse
//
// Optional build macro ALU_EXEC_CTRL_STATS_EN adds 16-bit outputs
// instr_count and taken_count (completed instructions / taken branches).
//
// state  | meaning
// S_IDLE | waiting for an instruction, inst_ready high
// S_EXEC | ALU controls for the latched instruction
// S_MEM  | memory request held until mem_ack (or timeout)
// S_TMO  | memory timeout, illegal pulse
// S_WB   | register writeback
// S_DONE | instruction complete, PC update allowed
// S_HALT | HLT executed, left only by reset
module alu_exec_ctrl #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inst_valid,
   output logic       inst_ready,
   input  logic [3:0] opcode,
   input  logic [5:0] func,
   output logic [4:0] alu_func_code,
   output logic       alu_src_imm,
   output logic       alu_op1_zero,
   input  logic       alu_b_result,
   output logic       mem_read,
   output logic       mem_write,
   input  logic       mem_ack,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       output_en,
   output logic       branch_taken,
   output logic       jump,
   output logic       done,
   output logic       halted,
`ifdef ALU_EXEC_CTRL_STATS_EN
   output logic [15:0] instr_count,
   output logic [15:0] taken_count,
`endif
   output logic       illegal
);

   // ALU function codes, same encoding as opcodes.v
   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_ORR = 5'd3;
   localparam logic [4:0] ALU_BNE = 5'd8;

   localparam logic [15:0] TMO_LOAD = 16'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MEM, S_TMO, S_WB, S_DONE, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_BR, C_LWD, C_SWD, C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_ILL
   } cls_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [5:0]  func_q, func_d;
   logic        taken_q, taken_d;
   logic [15:0] tmo_q, tmo_d;

   cls_t        cls;
   logic [4:0]  dec_alu;
   logic        dec_imm;
   logic        dec_op1z;

   // decode of the latched instruction
   always_comb begin
      cls      = C_ILL;
      dec_alu  = ALU_ADD;
      dec_imm  = 1'b0;
      dec_op1z = 1'b0;
      case (op_q)
         4'd0, 4'd1, 4'd2, 4'd3: begin
            cls     = C_BR;
            dec_alu = ALU_BNE + {3'd0, op_q[1:0]};
         end
         4'd4: begin cls = C_ALU; dec_imm = 1'b1; end
         4'd5: begin cls = C_ALU; dec_alu = ALU_ORR; dec_imm = 1'b1; end
         4'd6: begin cls = C_ALU; dec_alu = ALU_ORR; dec_imm = 1'b1; dec_op1z = 1'b1; end
         4'd7: begin cls = C_LWD; dec_imm = 1'b1; end
         4'd8: begin cls = C_SWD; dec_imm = 1'b1; end
         4'd9:  cls = C_JMP;
         4'd10: cls = C_JAL;
         4'd15: begin
            if (func_q < 6'd8) begin
               cls     = C_ALU;
               dec_alu = {2'b00, func_q[2:0]};
            end else begin
               case (func_q)
                  6'd25:   cls = C_WWD;
                  6'd26:   cls = C_JPR;
                  6'd27:   cls = C_JRL;
                  6'd28:   cls = C_HLT;
                  default: cls = C_ILL;
               endcase
            end
         end
         default: cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         func_q  <= 6'd0;
         taken_q <= 1'b0;
         tmo_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         func_q  <= func_d;
         taken_q <= taken_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      func_d        = func_q;
      taken_d       = taken_q;
      tmo_d         = tmo_q;
      inst_ready    = 1'b0;
      alu_func_code = 5'd0;
      alu_src_imm   = 1'b0;
      alu_op1_zero  = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'd0;
      output_en     = 1'b0;
      branch_taken  = 1'b0;
      jump          = 1'b0;
      done          = 1'b0;
      halted        = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         S_IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               op_d    = opcode;
               func_d  = func;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_func_code = dec_alu;
            alu_src_imm   = dec_imm;
            alu_op1_zero  = dec_op1z;
            taken_d       = 1'b0;
            tmo_d         = TMO_LOAD;
            case (cls)
               C_BR: begin
                  taken_d = alu_b_result;
                  state_d = S_DONE;
               end
               C_LWD, C_SWD:       state_d = S_MEM;
               C_ALU, C_JAL, C_JRL: state_d = S_WB;
               C_WWD: begin
                  output_en = 1'b1;
                  state_d   = S_DONE;
               end
               C_JMP, C_JPR:       state_d = S_DONE;
               C_HLT:              state_d = S_HALT;
               default: begin
                  illegal = 1'b1;
                  state_d = S_DONE;
               end
            endcase
         end
         S_MEM: begin
            alu_func_code = ALU_ADD;
            alu_src_imm   = 1'b1;
            mem_read      = (cls == C_LWD);
            mem_write     = (cls == C_SWD);
            if (mem_ack) begin
               state_d = (cls == C_LWD) ? S_WB : S_DONE;
            end else if (MEM_TIMEOUT > 0) begin
               // tmo_q holds the MEM cycles left including this one
               if (tmo_q <= 16'd1) state_d = S_TMO;
               else                tmo_d   = tmo_q - 16'd1;
            end
         end
         S_TMO: begin
            illegal = 1'b1;
            state_d = S_DONE;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (cls == C_LWD)                        wb_sel = 2'd1;
            else if ((cls == C_JAL) || (cls == C_JRL)) wb_sel = 2'd2;
            state_d = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            branch_taken = taken_q;
            jump         = (cls == C_JMP) || (cls == C_JAL) || (cls == C_JPR) || (cls == C_JRL);
            state_d      = S_IDLE;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ALU_EXEC_CTRL_STATS_EN
   logic [15:0] instr_cnt_q;
   logic [15:0] taken_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instr_cnt_q <= 16'd0;
         taken_cnt_q <= 16'd0;
      end else if (state_q == S_DONE) begin
         instr_cnt_q <= instr_cnt_q + 16'd1;
         if (taken_q) taken_cnt_q <= taken_cnt_q + 16'd1;
      end
   end

   assign instr_count = instr_cnt_q;
   assign taken_count = taken_cnt_q;
`endif

endmodule
